// File: rtl/cpu_muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one bit per clock, fixed WIDTH-cycle
// latency, single-cycle write request towards cpu_reg.
module cpu_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [REG_ADDR-1:0] dest,
    output logic                busy,
    output logic                write,
    output logic [REG_ADDR-1:0] write_reg,
    output logic [WIDTH-1:0]    write_data
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    logic [1:0]          state;
    logic [CW-1:0]       count;
    logic [1:0]          op_q;
    logic [REG_ADDR-1:0] dest_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [2*WIDTH-1:0]  prod;
    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    quo;

    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  prod_next;
    logic [WIDTH:0]      div_shift;
    logic [WIDTH:0]      div_diff;
    logic [WIDTH-1:0]    rem_next;
    logic [WIDTH-1:0]    quo_next;
    logic [WIDTH-1:0]    result_next;

    assign busy  = (state != IDLE);
    assign write = (state == DONE);

    // Both datapaths step every RUN cycle; op_q only picks which one is reported.
    // Multiply keeps the multiplier in the low half of prod and shifts it out LSB first.
    // Divide forms a WIDTH+1-bit trial remainder, so a zero divisor naturally
    // yields an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        mul_sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? a_q : {WIDTH{1'b0}})};
        prod_next   = {mul_sum, prod[WIDTH-1:1]};
        div_shift   = {rem, quo[WIDTH-1]};
        div_diff    = div_shift - {1'b0, b_q};
        rem_next    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        quo_next    = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
        result_next = prod_next[WIDTH-1:0];
        case (op_q)
            OP_MUL:   result_next = prod_next[WIDTH-1:0];
            OP_MULHU: result_next = prod_next[2*WIDTH-1:WIDTH];
            OP_DIVU:  result_next = quo_next;
            OP_REMU:  result_next = rem_next;
            default:  result_next = prod_next[WIDTH-1:0];
        endcase
    end

    // Start is only looked at in IDLE, so requests during RUN or DONE are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            op_q       <= '0;
            dest_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            prod       <= '0;
            rem        <= '0;
            quo        <= '0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        dest_q <= dest;
                        count  <= '0;
                        prod   <= {{WIDTH{1'b0}}, b};
                        rem    <= '0;
                        quo    <= a;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    prod  <= prod_next;
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        write_reg  <= dest_q;
                        write_data <= result_next;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// Self-checking bench for cpu_muldiv_unit: directed and random ops against an
// arithmetic reference, plus busy-start rejection and mid-operation reset.
module tb_cpu_muldiv_unit;

    localparam int WIDTH    = 32;
    localparam int REG_ADDR = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [1:0]          op = 2'b00;
    logic [WIDTH-1:0]    a = '0;
    logic [WIDTH-1:0]    b = '0;
    logic [REG_ADDR-1:0] dest = '0;
    logic                busy;
    logic                write;
    logic [REG_ADDR-1:0] write_reg;
    logic [WIDTH-1:0]    write_data;

    int assertion_count = 0;
    int fail_count      = 0;
    int write_pulses    = 0;
    int expected_pulses = 0;

    cpu_muldiv_unit #(.WIDTH(WIDTH), .REG_ADDR(REG_ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .dest       (dest),
        .busy       (busy),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data)
    );

    always #5 clk = ~clk;

    // Every write cycle spans one falling edge, so this counts pulses exactly.
    always @(negedge clk) begin
        if (write === 1'b1) write_pulses++;
    end

    function automatic logic [WIDTH-1:0] ref_result(input logic [1:0] o,
                                                     input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] p;
        logic [WIDTH-1:0]   r;
        p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
        case (o)
            2'b00:   r = p[WIDTH-1:0];
            2'b01:   r = p[2*WIDTH-1:WIDTH];
            2'b10:   r = (y == 0) ? {WIDTH{1'b1}} : x / y;
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertion_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic check_output(input string tag, input logic [REG_ADDR-1:0] exp_reg,
                                input logic [WIDTH-1:0] exp_data);
        check({tag, "_write"}, {63'd0, write}, 64'd1);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        check({tag, "_reg"}, {59'd0, write_reg}, {59'd0, exp_reg});
        check({tag, "_data"}, {32'd0, write_data}, {32'd0, exp_data});
    endtask

    // Runs one op through the full fixed latency; inject_busy_start holds a
    // competing start from mid-RUN through the DONE cycle.
    task automatic apply_stimulus(input string tag, input logic [1:0] o,
                                  input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic [REG_ADDR-1:0] d, input bit inject_busy_start);
        logic [WIDTH-1:0] exp_data;
        exp_data = ref_result(o, x, y);
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        dest  = d;
        @(posedge clk);
        #1;
        check({tag, "_accept"}, {63'd0, busy}, 64'd1);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        dest  = REG_ADDR'($urandom);
        op    = 2'($urandom);
        for (int i = 1; i < WIDTH; i++) begin
            @(posedge clk);
            #1;
            if (inject_busy_start && i == 10) begin
                start = 1'b1;
                op    = 2'b00;
                a     = 9;
                b     = 9;
                dest  = 5'd9;
            end
        end
        check({tag, "_early"}, {63'd0, write}, 64'd0);
        @(posedge clk);
        #1;
        expected_pulses++;
        check_output(tag, d, exp_data);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_strobe_end"}, {63'd0, write}, 64'd0);
        check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        check({tag, "_hold"}, {32'd0, write_data}, {32'd0, exp_data});
    endtask

    initial begin
        logic [1:0]       r_op;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;

        #12;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_write", {63'd0, write}, 64'd0);
        check("reset_reg", {59'd0, write_reg}, 64'd0);
        check("reset_data", {32'd0, write_data}, 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;

        apply_stimulus("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd3, 1'b0);
        apply_stimulus("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
        apply_stimulus("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b0);
        apply_stimulus("divu_100_7", 2'b10, 32'd100, 32'd7, 5'd5, 1'b0);
        apply_stimulus("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 1'b0);
        apply_stimulus("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 5'd6, 1'b0);
        apply_stimulus("remu_zero", 2'b11, 32'h1234_5678, 32'd0, 5'd7, 1'b0);
        apply_stimulus("divu_small", 2'b10, 32'd5, 32'd1000, 5'd8, 1'b0);
        apply_stimulus("remu_small", 2'b11, 32'd5, 32'd1000, 5'd8, 1'b0);
        apply_stimulus("dest_zero", 2'b00, 32'd3, 32'd4, 5'd0, 1'b0);
        apply_stimulus("busy_start", 2'b00, 32'd11, 32'd13, 5'd12, 1'b1);

        repeat (WIDTH + 4) @(posedge clk);
        #1;
        check("busy_start_pulses", 64'(write_pulses), 64'(expected_pulses));

        // Reset in the middle of a multiply must abort it with no write.
        wait_idle();
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd123;
        b     = 32'd456;
        dest  = 5'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_write", {63'd0, write}, 64'd0);
        check("abort_data", {32'd0, write_data}, 64'd0);
        check("abort_reg", {59'd0, write_reg}, 64'd0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        repeat (WIDTH + 4) @(posedge clk);
        #1;
        check("abort_no_write", 64'(write_pulses), 64'(expected_pulses));
        apply_stimulus("after_reset", 2'b10, 32'd1000, 32'd10, 5'd31, 1'b0);

        for (int k = 0; k < 8; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (k % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            apply_stimulus("random", r_op, r_a, r_b, REG_ADDR'($urandom), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("total_pulses", 64'(write_pulses), 64'(expected_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
        $finish;
    end

endmodule

// File: doc/cpu_muldiv_unit.md
Name: cpu_muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide execute unit.
- Consumes operand pair from cpu_reg read1/read2 plus destination index; produces a single-cycle write request (write, write_reg, write_data) that drives cpu_reg's write port.
- Iterative: one bit per clock; start/busy handshake with issue logic.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count.
- REG_ADDR, 5, register index width; matches cpu_reg.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  operation request; sampled only when busy=0.
- op  input  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient), 11 REMU (remainder).
- a  input  WIDTH  operand A / dividend, from read1.
- b  input  WIDTH  operand B / divisor, from read2.
- dest  input  REG_ADDR  destination register index.
- busy  output  1  high from accept through the write cycle.
- write  output  1  one-cycle write strobe to cpu_reg.
- write_reg  output  REG_ADDR  destination index, valid while write=1.
- write_data  output  WIDTH  result, valid while write=1.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0, write=0, write_reg=0, write_data=0; iteration counter and working registers cleared. Any operation in flight is aborted with no write.
- States: IDLE, RUN, DONE.
- IDLE: busy=0.
  - On an edge with start=1: latch a, b, op, dest; counter=0; go RUN.
  - start=0: stay IDLE.
- RUN: busy=1; one iteration per edge; after the WIDTH-th iteration go DONE.
  - Multiply: shift-add into a 2*WIDTH product.
    - MUL returns product[WIDTH-1:0].
    - MULHU returns product[2*WIDTH-1:WIDTH].
  - Divide: restoring, MSB first; WIDTH+1-bit partial remainder; quotient bit 1 when trial subtraction is non-negative.
- DONE: busy=1, write=1 for exactly one cycle; write_reg=latched dest; write_data=selected result; next edge go IDLE.
- Latency: write is high in the cycle following the WIDTH-th edge after the accepting edge. This is fixed for every op and every operand value, with no early termination.
- Handshake: start while busy=1 is ignored (not queued), including during the DONE cycle. A new start is accepted on the first edge with busy=0.
  - Back-to-back throughput: one op per WIDTH+2 cycles.
- Operands: inputs a/b/op/dest may change after the accepting edge without affecting the result.
- Output holding: write_data and write_reg hold their last value after DONE until the next DONE. write is 0 outside DONE.
- Divide by zero (b=0): full latency; DIVU result = all ones (0xFFFFFFFF); REMU result = a.
- Divisor > dividend: quotient 0, remainder = a.
- dest=0: the write strobe is still issued. Suppression, if any, belongs to cpu_reg.
- Arithmetic: all unsigned, modulo 2^WIDTH on the result; no overflow flags.
- Reset deasserted mid-cycle: the first active edge after release sees IDLE.

Test Plan:
- MUL a=7, b=6, dest=3 -> after 32 edges in RUN, write=1 for one cycle, write_reg=3, write_data=42; busy falls the cycle after.
- MULHU and MUL with a=b=0xFFFFFFFF -> MULHU write_data=0xFFFFFFFE; a separate MUL gives 0x00000001.
- DIVU a=100, b=7, dest=5 -> write_data=14; REMU on the same operands -> write_data=2; latency identical to MUL.
- Divide by zero, a=0x12345678, b=0 -> DIVU write_data=0xFFFFFFFF; REMU write_data=0x12345678; no hang.
- Start pulse with a=9, b=9 issued while busy (mid-RUN and in the DONE cycle) -> ignored. Only the original op writes; exactly one write pulse per accepted start.
- Assert reset=0 at iteration 10 of a MUL -> busy=0, write=0, write_data=0 immediately. No write after release; the next start completes normally.
